// File: rtl/uart_frame_parser.sv
// UART frame parser: SOF, LEN, payload, CHK -> buffered valid/ready stream.
// Optional inter-byte timeout enabled by UART_FRAME_TIMEOUT_EN.
module uart_frame_parser #(
  parameter int          MAX_PAYLOAD   = 16,
  parameter logic [7:0]  SOF_BYTE      = 8'hAA,
  parameter int          TIMEOUT_TICKS = 160
) (
  input  logic       clk_50MHz,
  input  logic       reset,
  input  logic       byte_valid,
  input  logic [7:0] byte_in,
  input  logic       sample_tick,
  output logic [7:0] pl_data,
  output logic       pl_valid,
  input  logic       pl_ready,
  output logic       pl_last,
  output logic [7:0] frame_len,
  output logic       frame_done,
  output logic       err_chk,
  output logic       err_len,
  output logic [7:0] drop_cnt,
  output logic       busy
);

  localparam int AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_PAYLOAD,
    S_CHK,
    S_DRAIN
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] widx_q, widx_d;
  logic [7:0] ridx_q, ridx_d;
  logic [7:0] chk_q, chk_d;
  logic [7:0] frame_len_q, frame_len_d;
  logic [7:0] pl_data_q, pl_data_d;
  logic       pl_valid_q, pl_valid_d;
  logic       pl_last_q, pl_last_d;
  logic       frame_done_q, frame_done_d;
  logic       err_chk_q, err_chk_d;
  logic       err_len_q, err_len_d;
  logic [7:0] drop_cnt_q, drop_cnt_d;
  logic       busy_q, busy_d;
  logic       wr_en;

  logic [7:0] mem_q [MAX_PAYLOAD];

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  logic [TW-1:0] tmo_q, tmo_d;
`else
  logic unused_tick;
  assign unused_tick = sample_tick;
`endif

  always_comb begin
    state_d      = state_q;
    widx_d       = widx_q;
    ridx_d       = ridx_q;
    chk_d        = chk_q;
    frame_len_d  = frame_len_q;
    pl_data_d    = pl_data_q;
    pl_valid_d   = pl_valid_q;
    pl_last_d    = pl_last_q;
    frame_done_d = 1'b0;
    err_chk_d    = 1'b0;
    err_len_d    = 1'b0;
    drop_cnt_d   = drop_cnt_q;
    wr_en        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (byte_valid && byte_in == SOF_BYTE) state_d = S_LEN;
      end
      S_LEN: begin
        if (byte_valid) begin
          if (byte_in == 8'd0 || byte_in > MAX_LEN) begin
            err_len_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            frame_len_d = byte_in;
            chk_d       = byte_in;
            widx_d      = 8'd0;
            state_d     = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (byte_valid) begin
          wr_en  = 1'b1;
          chk_d  = chk_q ^ byte_in;
          widx_d = widx_q + 8'd1;
          if (widx_q == frame_len_q - 8'd1) state_d = S_CHK;
        end
      end
      S_CHK: begin
        if (byte_valid) begin
          if (byte_in == chk_q) begin
            frame_done_d = 1'b1;
            ridx_d       = 8'd0;
            pl_valid_d   = 1'b1;
            pl_data_d    = mem_q[0];
            pl_last_d    = (frame_len_q == 8'd1);
            state_d      = S_DRAIN;
          end else begin
            err_chk_d = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end
      S_DRAIN: begin
        // Consumer owns the buffer now; new bytes can only be counted.
        if (byte_valid && drop_cnt_q != 8'hFF)
          drop_cnt_d = drop_cnt_q + 8'd1;
        if (pl_valid_q && pl_ready) begin
          if (pl_last_q) begin
            pl_valid_d = 1'b0;
            pl_last_d  = 1'b0;
            state_d    = S_IDLE;
          end else begin
            ridx_d    = ridx_q + 8'd1;
            pl_data_d = mem_q[ridx_d[AW-1:0]];
            pl_last_d = (ridx_d == frame_len_q - 8'd1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef UART_FRAME_TIMEOUT_EN
    tmo_d = '0;
    if (state_q == S_LEN || state_q == S_PAYLOAD || state_q == S_CHK) begin
      if (byte_valid)       tmo_d = '0;
      else if (sample_tick) tmo_d = tmo_q + 1'b1;
      else                  tmo_d = tmo_q;
      if (tmo_d == TW'(TIMEOUT_TICKS)) begin
        tmo_d     = '0;
        err_len_d = 1'b1;
        state_d   = S_IDLE;
      end
    end
`endif
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      widx_q       <= 8'd0;
      ridx_q       <= 8'd0;
      chk_q        <= 8'd0;
      frame_len_q  <= 8'd0;
      pl_data_q    <= 8'd0;
      pl_valid_q   <= 1'b0;
      pl_last_q    <= 1'b0;
      frame_done_q <= 1'b0;
      err_chk_q    <= 1'b0;
      err_len_q    <= 1'b0;
      drop_cnt_q   <= 8'd0;
      busy_q       <= 1'b0;
`ifdef UART_FRAME_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      widx_q       <= widx_d;
      ridx_q       <= ridx_d;
      chk_q        <= chk_d;
      frame_len_q  <= frame_len_d;
      pl_data_q    <= pl_data_d;
      pl_valid_q   <= pl_valid_d;
      pl_last_q    <= pl_last_d;
      frame_done_q <= frame_done_d;
      err_chk_q    <= err_chk_d;
      err_len_q    <= err_len_d;
      drop_cnt_q   <= drop_cnt_d;
      busy_q       <= busy_d;
`ifdef UART_FRAME_TIMEOUT_EN
      tmo_q        <= tmo_d;
`endif
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (wr_en) mem_q[widx_q[AW-1:0]] <= byte_in;
  end

  assign pl_data    = pl_data_q;
  assign pl_valid   = pl_valid_q;
  assign pl_last    = pl_last_q;
  assign frame_len  = frame_len_q;
  assign frame_done = frame_done_q;
  assign err_chk    = err_chk_q;
  assign err_len    = err_len_q;
  assign drop_cnt   = drop_cnt_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser.
// Timeout expectations follow UART_FRAME_TIMEOUT_EN.
module tb_uart_frame_parser;

  logic       clk_50MHz = 1'b0;
  logic       reset;
  logic       byte_valid;
  logic [7:0] byte_in;
  logic       sample_tick;
  logic [7:0] pl_data;
  logic       pl_valid;
  logic       pl_ready;
  logic       pl_last;
  logic [7:0] frame_len;
  logic       frame_done;
  logic       err_chk;
  logic       err_len;
  logic [7:0] drop_cnt;
  logic       busy;

  int checks = 0;
  int failures = 0;
  logic [7:0] expq[$];

  always #5 clk_50MHz = ~clk_50MHz;

  uart_frame_parser dut (
    .clk_50MHz  (clk_50MHz),
    .reset      (reset),
    .byte_valid (byte_valid),
    .byte_in    (byte_in),
    .sample_tick(sample_tick),
    .pl_data    (pl_data),
    .pl_valid   (pl_valid),
    .pl_ready   (pl_ready),
    .pl_last    (pl_last),
    .frame_len  (frame_len),
    .frame_done (frame_done),
    .err_chk    (err_chk),
    .err_len    (err_len),
    .drop_cnt   (drop_cnt),
    .busy       (busy)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk_50MHz);
    byte_valid = 1'b1;
    byte_in    = b;
    @(negedge clk_50MHz);
    byte_valid = 1'b0;
    byte_in    = 8'h00;
  endtask

  task automatic frame(input logic [7:0] len, input logic [7:0] chk);
    send(8'hAA);
    send(len);
    foreach (expq[i]) send(expq[i]);
    send(chk);
  endtask

  task automatic drain(input bit bp);
    int k = 0;
    int cyc = 0;
    while (k < expq.size() && cyc < 200) begin
      pl_ready = bp ? (cyc % 2 == 1) : 1'b1;
      if (cyc == 1) check("done_pulse", frame_done, 0);
      check("pl_valid", pl_valid, 1);
      if (pl_valid) begin
        check("pl_data", pl_data, expq[k]);
        check("pl_last", pl_last, k == expq.size() - 1);
        if (pl_ready) k++;
      end
      @(negedge clk_50MHz);
      cyc++;
    end
    pl_ready = 1'b0;
    check("drain_cnt", k, expq.size());
    check("valid_off", pl_valid, 0);
    check("last_off", pl_last, 0);
    check("busy_off", busy, 0);
  endtask

  initial begin
    int errs;
    reset       = 1'b0;
    byte_valid  = 1'b0;
    byte_in     = 8'h00;
    sample_tick = 1'b0;
    pl_ready    = 1'b0;
    repeat (2) @(negedge clk_50MHz);
    check("rst_pl_data", pl_data, 0);
    check("rst_pl_valid", pl_valid, 0);
    check("rst_pl_last", pl_last, 0);
    check("rst_frame_len", frame_len, 0);
    check("rst_done", frame_done, 0);
    check("rst_err_chk", err_chk, 0);
    check("rst_err_len", err_len, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_busy", busy, 0);
    reset = 1'b1;
    @(negedge clk_50MHz);

    send(8'h12);
    send(8'h34);
    check("garbage_drop", drop_cnt, 0);
    check("garbage_busy", busy, 0);

    expq = '{8'h11, 8'h22, 8'h33};
    frame(8'd3, 8'h03);
    check("good_done", frame_done, 1);
    check("good_len", frame_len, 3);
    check("good_busy", busy, 1);
    check("good_err", {err_chk, err_len}, 0);
    drain(1'b0);

    frame(8'd3, 8'h03);
    check("bp_done", frame_done, 1);
    drain(1'b1);

    // expected checksum is 02^55^66 = 31
    expq = '{8'h55, 8'h66};
    frame(8'd2, 8'h00);
    check("bad_err_chk", err_chk, 1);
    check("bad_no_valid", pl_valid, 0);
    check("bad_no_done", frame_done, 0);
    check("bad_busy", busy, 0);
    @(negedge clk_50MHz);
    check("bad_pulse_1cyc", err_chk, 0);

    expq = '{8'h5A};
    frame(8'd1, 8'h5B);
    check("after_bad_done", frame_done, 1);
    check("after_bad_len", frame_len, 1);
    drain(1'b0);

    send(8'hAA);
    send(8'h00);
    check("len0_err", err_len, 1);
    check("len0_busy", busy, 0);
    @(negedge clk_50MHz);
    check("len0_pulse_1cyc", err_len, 0);
    send(8'hAA);
    send(8'h11);
    check("len17_err", err_len, 1);
    check("len17_hold_len", frame_len, 1);
    send(8'hAA);
    send(8'hAA);
    check("lenAA_err", err_len, 1);

    expq.delete();
    for (int i = 0; i < 16; i++) expq.push_back(8'(i));
    frame(8'd16, 8'h10);
    check("max_done", frame_done, 1);
    check("max_len", frame_len, 16);
    drain(1'b1);

    expq = '{8'h77};
    frame(8'd1, 8'h76);
    check("drop_done", frame_done, 1);
    for (int i = 0; i < 10; i++) send(8'(i));
    check("drop_10", drop_cnt, 10);
    for (int i = 0; i < 290; i++) send(8'(i));
    check("drop_sat", drop_cnt, 255);
    check("drop_still_valid", pl_valid, 1);
    drain(1'b0);
    check("drop_kept", drop_cnt, 255);

    send(8'hAA);
    send(8'h04);
    send(8'h11);
    check("mid_busy", busy, 1);
    #2 reset = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_drop", drop_cnt, 0);
    check("arst_len", frame_len, 0);
    check("arst_valid", pl_valid, 0);
    check("arst_pulses", {frame_done, err_chk, err_len}, 0);
    @(negedge clk_50MHz);
    reset = 1'b1;
    @(negedge clk_50MHz);
    check("post_rst_pulses", {frame_done, err_chk, err_len}, 0);

    send(8'hAA);
    send(8'h04);
    send(8'h11);
    errs = 0;
    sample_tick = 1'b1;
    for (int i = 0; i < 170; i++) begin
      @(negedge clk_50MHz);
      if (err_len) errs++;
    end
    sample_tick = 1'b0;
    @(negedge clk_50MHz);
`ifdef UART_FRAME_TIMEOUT_EN
    check("tmo_err_pulses", errs, 1);
    check("tmo_busy", busy, 0);
`else
    check("tmo_err_pulses", errs, 0);
    check("tmo_busy", busy, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
